// File: rtl/kpn_split_n_if.sv
// Signal bundle between the KPN fork process and its surrounding FIFOs.
// The master side is the fork process itself; the slave side is the
// environment (upstream FIFO read port plus the downstream FIFO write ports).
interface kpn_split_n_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 2,
    parameter int CNT_WIDTH  = 16
);
    logic                  mode;
    logic                  in_empty;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  rd;
    logic [NUM_OUT-1:0]    out_full;
    logic [NUM_OUT-1:0]    wr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  tok_count;

    modport master (
        input  mode, in_empty, in_data, out_full,
        output rd, wr, out_data, busy, tok_count
    );

    modport slave (
        output mode, in_empty, in_data, out_full,
        input  rd, wr, out_data, busy, tok_count
    );
endinterface

// File: rtl/kpn_split_n.sv
// KPN fork process: reads one token at a time from an upstream FIFO and
// delivers it either to every output channel (broadcast) or to a single
// channel chosen in rotating order (distribute). Each channel is written at
// most once per token and only while it has space, so backpressure on one
// channel never drops or duplicates a token on another.
module kpn_split_n #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_OUT    = 2,
    parameter int CNT_WIDTH  = 16
) (
    input logic           clk,
    input logic           rst,
    kpn_split_n_if.master bus
);
    localparam int PTR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [NUM_OUT-1:0]    pend_mask;
    logic [NUM_OUT-1:0]    pend_next;
    logic [NUM_OUT-1:0]    rr_onehot;
    logic [NUM_OUT-1:0]    wr_c;
    logic [PTR_W-1:0]      rr_ptr;
    logic                  mode_lat;
    logic [CNT_WIDTH-1:0]  tok_count;
    logic                  rd_c;
    logic                  done;

    assign rr_onehot = NUM_OUT'(1) << rr_ptr;

    // Read/write strobes: reads only when the FSM can accept a token, writes
    // only to channels still owed this token and currently not full.
    always_comb begin
        rd_c      = 1'b0;
        wr_c      = '0;
        pend_next = pend_mask;
        done      = 1'b0;
        case (state)
            IDLE: begin
                rd_c = ~bus.in_empty;
            end
            HOLD: begin
                wr_c      = pend_mask & ~bus.out_full;
                pend_next = pend_mask & ~wr_c;
                done      = (pend_next == '0);
                // Chaining the next read into the completing cycle gives
                // one token every two cycles without backpressure.
                rd_c      = done & ~bus.in_empty;
            end
            default: ;
        endcase
        // Strobes stay quiet for the whole time reset is held.
        if (rst) begin
            rd_c = 1'b0;
            wr_c = '0;
        end
    end

    // Token FSM: latch token and mode in FETCH, drain the pending channel
    // mask in HOLD, then count the token and advance the rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_reg  <= '0;
            pend_mask <= '0;
            rr_ptr    <= '0;
            mode_lat  <= 1'b0;
            tok_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_c) state <= FETCH;
                end
                FETCH: begin
                    hold_reg  <= bus.in_data;
                    mode_lat  <= bus.mode;
                    pend_mask <= bus.mode ? rr_onehot : '1;
                    state     <= HOLD;
                end
                HOLD: begin
                    pend_mask <= pend_next;
                    if (done) begin
                        tok_count <= tok_count + 1'b1;
                        // Broadcast tokens leave the rotation untouched.
                        if (mode_lat) begin
                            rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
                        end
                        state <= rd_c ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // out_data is the held token; it keeps the last value outside HOLD.
    assign bus.rd        = rd_c;
    assign bus.wr        = wr_c;
    assign bus.out_data  = hold_reg;
    assign bus.busy      = (state != IDLE);
    assign bus.tok_count = tok_count;
endmodule

// File: tb/tb_kpn_split_n.sv
// Bench for kpn_split_n with three output channels. An upstream FIFO with
// 1-cycle read latency is modelled by a queue; a token-level reference
// tracks which channels still owe the current token, the rotation position
// and the delivered-token count.
module tb_kpn_split_n;
    localparam int DW = 16;
    localparam int NO = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kpn_split_n_if #(.DATA_WIDTH(DW), .NUM_OUT(NO), .CNT_WIDTH(CW)) bus ();

    kpn_split_n #(.DATA_WIDTH(DW), .NUM_OUT(NO), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Upstream FIFO contents and a forced-empty stall flag.
    logic [DW-1:0] src_q[$];
    bit            stall;

    // Reference model state.
    logic [DW-1:0] fetched;
    logic [DW-1:0] cur_data;
    logic [NO-1:0] cur_pend;
    bit            cur_dist;
    bit            fetch_next;
    int            m_rr;
    logic [CW-1:0] m_tok;

    // Values sampled from the DUT and predicted by the model each cycle.
    logic [NO-1:0] obs_wr,   exp_wr;
    logic          obs_rd,   exp_rd;
    logic          obs_busy, exp_busy;
    logic [DW-1:0] obs_data, exp_data;
    logic [CW-1:0] obs_tok,  exp_tok;

    task automatic model_reset();
        cur_data   = '0;
        cur_pend   = '0;
        cur_dist   = 1'b0;
        fetch_next = 1'b0;
        m_rr       = 0;
        m_tok      = '0;
        fetched    = '0;
    endtask

    // One clock cycle: drive in_empty, sample DUT outputs mid-cycle, predict
    // them from the token-level model, then advance the FIFO across the edge.
    task automatic tick();
        bus.in_empty = stall || (src_q.size() == 0);
        @(negedge clk);
        obs_wr   = bus.wr;
        obs_rd   = bus.rd;
        obs_busy = bus.busy;
        obs_data = bus.out_data;
        obs_tok  = bus.tok_count;
        exp_tok  = m_tok;
        exp_data = cur_data;
        if (fetch_next) begin
            // Token arrives from the FIFO this cycle; nothing is written yet.
            exp_wr     = '0;
            exp_rd     = 1'b0;
            exp_busy   = 1'b1;
            cur_dist   = bus.mode;
            cur_pend   = bus.mode ? (NO'(1) << m_rr) : '1;
            cur_data   = fetched;
            fetch_next = 1'b0;
        end else begin
            exp_wr   = cur_pend & ~bus.out_full;
            exp_busy = (cur_pend != '0);
            exp_rd   = ((cur_pend & ~exp_wr) == '0) && !bus.in_empty;
            if (cur_pend != '0 && (cur_pend & ~exp_wr) == '0) begin
                m_tok = m_tok + 1'b1;
                if (cur_dist) m_rr = (m_rr + 1) % NO;
            end
            cur_pend = cur_pend & ~exp_wr;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_rd && src_q.size() > 0) begin
            fetched     = src_q.pop_front();
            bus.in_data = fetched;
            fetch_next  = 1'b1;
        end else begin
            bus.in_data = DW'($urandom);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_empty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk += 5;
        if (bus.rd !== 1'b0) $display("FAIL rst_rd got=%b want=0", bus.rd); else n_pass++;
        if (bus.wr !== '0) $display("FAIL rst_wr got=%b want=000", bus.wr); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL rst_busy got=%b want=0", bus.busy); else n_pass++;
        if (bus.out_data !== '0) $display("FAIL rst_data got=%h want=0000", bus.out_data); else n_pass++;
        if (bus.tok_count !== '0) $display("FAIL rst_tok got=%0d want=0", bus.tok_count); else n_pass++;
        rst = 1'b0;
        model_reset();
        repeat (2) begin
            tick();
            n_chk += 3;
            if (obs_wr !== exp_wr) $display("FAIL rst_idle_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL rst_idle_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL rst_idle_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
        end
    endtask

    task automatic test_empty_input();
        int rd_pulses = 0;
        bus.mode = 1'b0;
        stall    = 1'b1;
        src_q.push_back(16'h7777);
        for (int i = 0; i < 15; i++) begin
            if (i == 10) stall = 1'b0;
            tick();
            if (i >= 10 && obs_rd) rd_pulses++;
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL empty_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL empty_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL empty_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL empty_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL empty_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        n_chk++;
        if (rd_pulses !== 1) $display("FAIL empty_rd_pulses got=%0d want=1", rd_pulses); else n_pass++;
    endtask

    task automatic test_broadcast();
        int            nev = 0;
        int            ev_cyc[4];
        logic [DW-1:0] ev_dat[4];
        logic [CW-1:0] tok_base = m_tok;
        bus.mode     = 1'b0;
        bus.out_full = '0;
        stall        = 1'b0;
        src_q.push_back(16'h1234);
        src_q.push_back(16'hABCD);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (obs_wr == 3'b111 && nev < 4) begin
                ev_cyc[nev] = cyc;
                ev_dat[nev] = obs_data;
                nev++;
            end
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL bcast_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL bcast_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL bcast_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL bcast_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL bcast_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        n_chk += 2;
        if (nev !== 2) $display("FAIL bcast_events got=%0d want=2", nev); else n_pass++;
        if (bus.tok_count !== tok_base + 16'd2) $display("FAIL bcast_count got=%0d want=%0d", bus.tok_count, tok_base + 16'd2); else n_pass++;
        if (nev == 2) begin
            n_chk += 3;
            if (ev_dat[0] !== 16'h1234) $display("FAIL bcast_first got=%h want=1234", ev_dat[0]); else n_pass++;
            if (ev_dat[1] !== 16'hABCD) $display("FAIL bcast_second got=%h want=abcd", ev_dat[1]); else n_pass++;
            if (ev_cyc[1] - ev_cyc[0] !== 2) $display("FAIL bcast_spacing got=%0d want=2", ev_cyc[1] - ev_cyc[0]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int            nev = 0;
        int            ev_cyc[4];
        logic [NO-1:0] ev_wr[4];
        logic [DW-1:0] ev_dat[4];
        logic [CW-1:0] tok_base = m_tok;
        bus.mode     = 1'b0;
        bus.out_full = 3'b010;
        stall        = 1'b0;
        src_q.push_back(16'h00FF);
        src_q.push_back(16'h0100);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_wr != '0 && nev < 4) begin
                ev_cyc[nev] = cyc;
                ev_wr[nev]  = obs_wr;
                ev_dat[nev] = obs_data;
                nev++;
            end
            // Channel 1 stays full for four cycles of HOLD (ticks 2..5).
            if (i == 5) bus.out_full = '0;
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL bp_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL bp_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL bp_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL bp_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL bp_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        n_chk += 2;
        if (nev !== 3) $display("FAIL bp_events got=%0d want=3", nev); else n_pass++;
        if (bus.tok_count !== tok_base + 16'd2) $display("FAIL bp_count got=%0d want=%0d", bus.tok_count, tok_base + 16'd2); else n_pass++;
        if (nev == 3) begin
            n_chk += 5;
            if (ev_wr[0] !== 3'b101) $display("FAIL bp_first_wr got=%b want=101", ev_wr[0]); else n_pass++;
            if (ev_wr[1] !== 3'b010) $display("FAIL bp_retry_wr got=%b want=010", ev_wr[1]); else n_pass++;
            if (ev_dat[1] !== 16'h00FF) $display("FAIL bp_retry_data got=%h want=00ff", ev_dat[1]); else n_pass++;
            if (ev_cyc[1] - ev_cyc[0] !== 4) $display("FAIL bp_retry_delay got=%0d want=4", ev_cyc[1] - ev_cyc[0]); else n_pass++;
            if (ev_dat[2] !== 16'h0100) $display("FAIL bp_next_data got=%h want=0100", ev_dat[2]); else n_pass++;
        end
    endtask

    task automatic test_distribute();
        int            nev = 0;
        logic [NO-1:0] ev_wr[8];
        logic [DW-1:0] ev_dat[8];
        logic [NO-1:0] want_wr[5];
        want_wr[0] = 3'b001; want_wr[1] = 3'b010; want_wr[2] = 3'b100;
        want_wr[3] = 3'b001; want_wr[4] = 3'b010;
        bus.mode     = 1'b1;
        bus.out_full = '0;
        stall        = 1'b0;
        for (int k = 1; k <= 4; k++) src_q.push_back(DW'(k));
        for (int i = 0; i < 16; i++) begin
            if (i == 11) src_q.push_back(16'h0005);
            tick();
            if (obs_wr != '0 && nev < 8) begin
                ev_wr[nev]  = obs_wr;
                ev_dat[nev] = obs_data;
                nev++;
            end
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL dist_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL dist_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL dist_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL dist_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL dist_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        n_chk++;
        if (nev !== 5) $display("FAIL dist_events got=%0d want=5", nev); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            if (k < nev) begin
                n_chk += 2;
                if (ev_wr[k] !== want_wr[k]) $display("FAIL dist_chan%0d got=%b want=%b", k, ev_wr[k], want_wr[k]); else n_pass++;
                if (ev_dat[k] !== DW'(k + 1)) $display("FAIL dist_tok%0d got=%h want=%h", k, ev_dat[k], DW'(k + 1)); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_in_hold();
        // Rotation sits at channel 2 after five distributed tokens.
        bus.mode     = 1'b1;
        bus.out_full = 3'b100;
        stall        = 1'b0;
        src_q.push_back(16'h0BAD);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk += 3;
            if (obs_wr !== exp_wr) $display("FAIL rsth_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL rsth_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL rsth_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
        end
        n_chk++;
        if (cur_pend !== 3'b100) $display("FAIL rsth_setup got=%b want=100", cur_pend); else n_pass++;
        stall = 1'b1;
        bus.in_empty = 1'b1;
        src_q.delete();
        #2;
        rst = 1'b1;
        #1;
        n_chk += 5;
        if (bus.rd !== 1'b0) $display("FAIL rsth_async_rd got=%b want=0", bus.rd); else n_pass++;
        if (bus.wr !== '0) $display("FAIL rsth_async_wr got=%b want=000", bus.wr); else n_pass++;
        if (bus.busy !== 1'b0) $display("FAIL rsth_async_busy got=%b want=0", bus.busy); else n_pass++;
        if (bus.out_data !== '0) $display("FAIL rsth_async_data got=%h want=0000", bus.out_data); else n_pass++;
        if (bus.tok_count !== '0) $display("FAIL rsth_async_tok got=%0d want=0", bus.tok_count); else n_pass++;
        model_reset();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_full = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk += 4;
            if (obs_wr !== 3'b000) $display("FAIL rsth_after_wr cyc=%0d got=%b want=000", cyc, obs_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL rsth_after_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL rsth_after_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_tok !== 16'd0) $display("FAIL rsth_after_tok cyc=%0d got=%0d want=0", cyc, obs_tok); else n_pass++;
        end
    endtask

    task automatic test_mode_switch();
        logic [NO-1:0] acc_a = '0;
        logic [NO-1:0] acc_b = '0;
        int            nb    = 0;
        bus.mode     = 1'b0;
        bus.out_full = 3'b001;
        stall        = 1'b0;
        src_q.push_back(16'h5555);
        src_q.push_back(16'h6666);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_wr != '0 && obs_data == 16'h5555) acc_a = acc_a | obs_wr;
            if (obs_wr != '0 && obs_data == 16'h6666) begin
                acc_b = acc_b | obs_wr;
                nb++;
            end
            if (i == 3) bus.mode = 1'b1;
            if (i == 5) bus.out_full = '0;
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL msw_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL msw_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL msw_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL msw_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL msw_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        n_chk += 3;
        if (acc_a !== 3'b111) $display("FAIL msw_a_chans got=%b want=111", acc_a); else n_pass++;
        if (acc_b !== 3'b001) $display("FAIL msw_b_chans got=%b want=001", acc_b); else n_pass++;
        if (nb !== 1) $display("FAIL msw_b_writes got=%0d want=1", nb); else n_pass++;
    endtask

    task automatic test_random();
        int guard = 0;
        for (int i = 0; i < 300; i++) begin
            bus.mode     = 1'($urandom % 2);
            bus.out_full = NO'($urandom);
            stall        = (($urandom % 4) == 0);
            if (($urandom % 2) == 0 && src_q.size() < 8) src_q.push_back(DW'($urandom));
            tick();
            n_chk += 5;
            if (obs_wr !== exp_wr) $display("FAIL rnd_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL rnd_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_busy !== exp_busy) $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); else n_pass++;
            if (obs_data !== exp_data) $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL rnd_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        // Drain everything still queued, bounded by a cycle budget.
        stall        = 1'b0;
        bus.out_full = '0;
        while ((src_q.size() > 0 || cur_pend != '0 || fetch_next) && guard < 100) begin
            tick();
            guard++;
            n_chk += 3;
            if (obs_wr !== exp_wr) $display("FAIL drain_wr cyc=%0d got=%b want=%b", cyc, obs_wr, exp_wr); else n_pass++;
            if (obs_rd !== exp_rd) $display("FAIL drain_rd cyc=%0d got=%b want=%b", cyc, obs_rd, exp_rd); else n_pass++;
            if (obs_tok !== exp_tok) $display("FAIL drain_tok cyc=%0d got=%0d want=%0d", cyc, obs_tok, exp_tok); else n_pass++;
        end
        tick();
        n_chk += 3;
        if (guard >= 100) $display("FAIL drain_timeout got=%0d cycles want<100", guard); else n_pass++;
        if (obs_busy !== 1'b0) $display("FAIL drain_idle got=%b want=0", obs_busy); else n_pass++;
        if (obs_tok !== m_tok) $display("FAIL drain_count got=%0d want=%0d", obs_tok, m_tok); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b1;
        bus.mode     = 1'b0;
        bus.out_full = '0;
        bus.in_data  = '0;
        bus.in_empty = 1'b1;
        model_reset();
        test_reset();
        test_empty_input();
        test_broadcast();
        test_backpressure();
        test_distribute();
        test_reset_in_hold();
        test_mode_switch();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
